// File: rtl/alu_reg_seq.sv
// Command sequencer for a register-file/ALU datapath. It registers one command, drives the operand
// addresses for SETTLE_CYCLES cycles, strobes the write, then holds the captured result until it is taken.
module alu_reg_seq #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Cmd_Valid,
   output logic        Cmd_Ready,
   input  logic [2:0]  Cmd_OP,
   input  logic [4:0]  Cmd_RA,
   input  logic [4:0]  Cmd_RB,
   input  logic [4:0]  Cmd_RW,
   input  logic        Cmd_WE,
   output logic [4:0]  R_Addr_A,
   output logic [4:0]  R_Addr_B,
   output logic [4:0]  W_Addr,
   output logic [2:0]  ALU_OP,
   output logic        Write_Reg,
   input  logic [31:0] W_Data,
   input  logic        ZF,
   input  logic        OF,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [31:0] Rsp_Data,
   output logic        Rsp_ZF,
   output logic        Rsp_OF,
   output logic        Rsp_WrSup,
   output logic [15:0] Op_Count
);

   typedef enum logic [1:0] {IDLE, ISSUE, WRITE, RESP} state_t;

   localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  settle_q, settle_d;
   logic [4:0]  ra_q, ra_d, rb_q, rb_d, rw_q, rw_d;
   logic [2:0]  op_q, op_d;
   logic        we_q, we_d;
   logic        wrsup_q, wrsup_d;
   logic [31:0] data_q, data_d;
   logic        zf_q, zf_d, of_q, of_d;
   logic [15:0] count_q, count_d;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples
   // the pre-edge values computed by the combinational block regardless of statement order.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         settle_q <= '0;
         ra_q     <= '0;
         rb_q     <= '0;
         rw_q     <= '0;
         op_q     <= '0;
         we_q     <= 1'b0;
         wrsup_q  <= 1'b0;
         data_q   <= '0;
         zf_q     <= 1'b0;
         of_q     <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         rw_q     <= rw_d;
         op_q     <= op_d;
         we_q     <= we_d;
         wrsup_q  <= wrsup_d;
         data_q   <= data_d;
         zf_q     <= zf_d;
         of_q     <= of_d;
         count_q  <= count_d;
      end
   end

   // NOTE: every signal written here first receives a default (hold its register value),
   // so no path through the case statement leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      rw_d     = rw_q;
      op_d     = op_q;
      we_d     = we_q;
      wrsup_d  = wrsup_q;
      data_d   = data_q;
      zf_d     = zf_q;
      of_d     = of_q;
      count_d  = count_q;

      case (state_q)
         IDLE: begin
            if (Cmd_Valid) begin
               state_d  = ISSUE;
               settle_d = '0;
               ra_d     = Cmd_RA;
               rb_d     = Cmd_RB;
               rw_d     = Cmd_RW;
               op_d     = Cmd_OP;
               we_d     = Cmd_WE;
               wrsup_d  = Cmd_WE && (Cmd_RW == 5'd0);
            end
         end
         ISSUE: begin
            if (settle_q == LAST_SETTLE) begin
               state_d  = WRITE;
               settle_d = '0;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         WRITE: begin
            // Captured on the same edge the register file writes, so a destination equal
            // to a source still reports the result computed from the old operand.
            state_d = RESP;
            data_d  = W_Data;
            zf_d    = ZF;
            of_d    = OF;
         end
         RESP: begin
            if (Rsp_Ready) begin
               state_d = IDLE;
               count_d = count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Cmd_Ready = (state_q == IDLE) && !Reset;
   assign Write_Reg = (state_q == WRITE) && we_q && (rw_q != 5'd0);
   assign Rsp_Valid = (state_q == RESP);
   assign R_Addr_A  = ra_q;
   assign R_Addr_B  = rb_q;
   assign W_Addr    = rw_q;
   assign ALU_OP    = op_q;
   assign Rsp_Data  = data_q;
   assign Rsp_ZF    = zf_q;
   assign Rsp_OF    = of_q;
   assign Rsp_WrSup = wrsup_q;
   assign Op_Count  = count_q;

endmodule

// File: tb/tb_alu_reg_seq.sv
// Directed bench for alu_reg_seq: a default instance and a SETTLE_CYCLES=4 instance share stimulus;
// expected responses are queued at acceptance and compared when the response transfers.
module tb_alu_reg_seq;

   logic        Clk = 1'b0;
   logic        reset_a, reset_b;
   logic        Cmd_Valid, Rsp_Ready, ZF, OF, Cmd_WE;
   logic [2:0]  Cmd_OP;
   logic [4:0]  Cmd_RA, Cmd_RB, Cmd_RW;
   logic [31:0] W_Data;

   logic        rdy_a, wr_a, rv_a, rzf_a, rof_a, sup_a;
   logic        rdy_b, wr_b, rv_b, rzf_b, rof_b, sup_b;
   logic [4:0]  ra_a, rb_a, rw_a, ra_b, rb_b, rw_b;
   logic [2:0]  op_a, op_b;
   logic [31:0] rd_a, rd_b;
   logic [15:0] cnt_a, cnt_b;

   // Observed outputs of whichever instance is under test.
   logic        sel;
   logic        m_rdy, m_wr, m_rv, m_zf, m_of, m_sup;
   logic [4:0]  m_ra, m_rb, m_rw;
   logic [2:0]  m_op;
   logic [31:0] m_data;
   logic [15:0] m_cnt;

   typedef struct {
      logic [31:0] data;
      logic        zf;
      logic        of;
      logic        wrsup;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_cnt_a = '0;
   logic [15:0] exp_cnt_b = '0;

   always #5 Clk = ~Clk;

   alu_reg_seq u_dut_a (
      .Clk(Clk), .Reset(reset_a), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(rdy_a),
      .Cmd_OP(Cmd_OP), .Cmd_RA(Cmd_RA), .Cmd_RB(Cmd_RB), .Cmd_RW(Cmd_RW), .Cmd_WE(Cmd_WE),
      .R_Addr_A(ra_a), .R_Addr_B(rb_a), .W_Addr(rw_a), .ALU_OP(op_a), .Write_Reg(wr_a),
      .W_Data(W_Data), .ZF(ZF), .OF(OF), .Rsp_Valid(rv_a), .Rsp_Ready(Rsp_Ready),
      .Rsp_Data(rd_a), .Rsp_ZF(rzf_a), .Rsp_OF(rof_a), .Rsp_WrSup(sup_a), .Op_Count(cnt_a)
   );

   alu_reg_seq #(.SETTLE_CYCLES(4)) u_dut_b (
      .Clk(Clk), .Reset(reset_b), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(rdy_b),
      .Cmd_OP(Cmd_OP), .Cmd_RA(Cmd_RA), .Cmd_RB(Cmd_RB), .Cmd_RW(Cmd_RW), .Cmd_WE(Cmd_WE),
      .R_Addr_A(ra_b), .R_Addr_B(rb_b), .W_Addr(rw_b), .ALU_OP(op_b), .Write_Reg(wr_b),
      .W_Data(W_Data), .ZF(ZF), .OF(OF), .Rsp_Valid(rv_b), .Rsp_Ready(Rsp_Ready),
      .Rsp_Data(rd_b), .Rsp_ZF(rzf_b), .Rsp_OF(rof_b), .Rsp_WrSup(sup_b), .Op_Count(cnt_b)
   );

   always_comb begin
      m_rdy  = sel ? rdy_b : rdy_a;
      m_wr   = sel ? wr_b  : wr_a;
      m_rv   = sel ? rv_b  : rv_a;
      m_zf   = sel ? rzf_b : rzf_a;
      m_of   = sel ? rof_b : rof_a;
      m_sup  = sel ? sup_b : sup_a;
      m_ra   = sel ? ra_b  : ra_a;
      m_rb   = sel ? rb_b  : rb_a;
      m_rw   = sel ? rw_b  : rw_a;
      m_op   = sel ? op_b  : op_a;
      m_data = sel ? rd_b  : rd_a;
      m_cnt  = sel ? cnt_b : cnt_a;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " write_reg"}, 32'(m_wr), 32'd0);
      check({tag, " rsp_valid"}, 32'(m_rv), 32'd0);
      check({tag, " addrs_op"}, {14'd0, m_ra, m_rb, m_rw, m_op}, 32'd0);
      check({tag, " rsp_data"}, m_data, 32'd0);
      check({tag, " flags"}, {29'd0, m_zf, m_of, m_sup}, 32'd0);
      check({tag, " op_count"}, 32'(m_cnt), 32'd0);
   endtask

   // Drives a command at a falling edge, waits (bounded) for acceptance, queues the expected response.
   task automatic accept_cmd(input logic [2:0] op, input logic [4:0] ra, input logic [4:0] rb,
                             input logic [4:0] rw, input logic we, input logic [31:0] data,
                             input logic zf, input logic of, output bit ok);
      exp_t e;
      ok = 1'b0;
      Cmd_Valid = 1'b1; Cmd_OP = op; Cmd_RA = ra; Cmd_RB = rb; Cmd_RW = rw; Cmd_WE = we;
      W_Data = data; ZF = zf; OF = of;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (m_rdy) ok = 1'b1;
         else @(negedge Clk);
      end
      if (!ok) begin
         check("accept_timeout", 32'(m_rdy), 32'd1);
         return;
      end
      e.data = data; e.zf = zf; e.of = of; e.wrsup = we && (rw == 5'd0);
      sb.push_back(e);
      @(posedge Clk);
      @(negedge Clk);
      // Fields change after acceptance and must not reach the datapath outputs.
      Cmd_Valid = 1'b0; Cmd_OP = ~op; Cmd_RA = ~ra; Cmd_RB = ~rb; Cmd_RW = ~rw; Cmd_WE = ~we;
   endtask

   // Full command: latency/strobe timing, optional response stall, transfer and scoreboard compare.
   task automatic run_cmd(input int s, input logic [2:0] op, input logic [4:0] ra,
                          input logic [4:0] rb, input logic [4:0] rw, input logic we,
                          input logic [31:0] data, input logic zf, input logic of, input int stall);
      bit   ok;
      exp_t e;
      accept_cmd(op, ra, rb, rw, we, data, zf, of, ok);
      if (!ok) return;
      check("dp_outputs", {14'd0, m_ra, m_rb, m_rw, m_op}, {14'd0, ra, rb, rw, op});
      for (int k = 1; k <= s + 2; k++) begin
         check($sformatf("write_reg_c%0d", k), 32'(m_wr), 32'((k == s + 1) && we && (rw != 5'd0)));
         check($sformatf("rsp_valid_c%0d", k), 32'(m_rv), 32'(k == s + 2));
         if (k == s + 1) check("w_addr_at_write", 32'(m_rw), 32'(rw));
         if (k < s + 2) @(negedge Clk);
      end
      W_Data = 32'hFFFF_FFFF; ZF = ~zf; OF = ~of;
      Cmd_Valid = 1'b1;
      for (int k = 0; k < stall; k++) begin
         check("stall_rsp_data", m_data, data);
         check("stall_handshake", {30'd0, m_rv, m_rdy}, 32'b10);
         @(negedge Clk);
      end
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      check("rsp_data", m_data, e.data);
      check("rsp_flags", {29'd0, m_zf, m_of, m_sup}, {29'd0, e.zf, e.of, e.wrsup});
      Rsp_Ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Rsp_Ready = 1'b0; Cmd_Valid = 1'b0;
      if (sel) exp_cnt_b = exp_cnt_b + 16'd1;
      else     exp_cnt_a = exp_cnt_a + 16'd1;
      check("op_count", 32'(m_cnt), 32'(sel ? exp_cnt_b : exp_cnt_a));
      check("idle_after_xfer", {30'd0, m_rv, m_rdy}, 32'b01);
   endtask

   initial begin
      bit ok;
      sel = 1'b0;
      reset_a = 1'b1; reset_b = 1'b1;
      Cmd_Valid = 1'b0; Rsp_Ready = 1'b0; Cmd_OP = '0; Cmd_RA = '0; Cmd_RB = '0; Cmd_RW = '0;
      Cmd_WE = 1'b0; W_Data = '0; ZF = 1'b0; OF = 1'b0;

      repeat (3) @(negedge Clk);
      check("ready_in_reset", 32'(m_rdy), 32'd0);
      check_reset_state("por");
      reset_a = 1'b0;
      @(negedge Clk);
      check("ready_after_reset", 32'(m_rdy), 32'd1);

      run_cmd(1, 3'b100, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 4);
      run_cmd(1, 3'b011, 5'd7, 5'd8, 5'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
      run_cmd(1, 3'b001, 5'd4, 5'd6, 5'd5, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
      run_cmd(1, 3'b111, 5'd31, 5'd0, 5'd31, 1'b1, 32'hA5A5_5A5A, 1'b1, 1'b1, 0);

      // Reset in the WRITE cycle: strobe must drop immediately and no response may follow.
      accept_cmd(3'b010, 5'd9, 5'd10, 5'd11, 1'b1, 32'h1234_5678, 1'b0, 1'b0, ok);
      if (ok) begin
         @(negedge Clk);
         check("strobe_before_reset", 32'(m_wr), 32'd1);
         #2 reset_a = 1'b1;
         #1 check("strobe_async_drop", 32'(m_wr), 32'd0);
         check("ready_in_midreset", 32'(m_rdy), 32'd0);
         exp_cnt_a = '0;
         sb.delete();
         for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("no_rsp_in_reset", {30'd0, m_rv, m_wr}, 32'd0);
         end
         check_reset_state("midcmd");
         reset_a = 1'b0;
         @(negedge Clk);
         check("ready_after_midreset", 32'(m_rdy), 32'd1);
         check("no_rsp_after_reset", 32'(m_rv), 32'd0);
      end

      // SETTLE_CYCLES=4 instance: six-cycle latency, back-to-back commands.
      reset_a = 1'b1;
      sel = 1'b1;
      @(negedge Clk);
      check_reset_state("por_b");
      reset_b = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 3; i++)
         run_cmd(4, 3'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b1, 32'hC0DE_0000 + 32'(i),
                 1'(i), 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

endmodule
